edp_diag_reader: RTL and testbench
==================================

Name: edp_diag_reader

Overview:
Front-end-side reader for the EDP diagnostic EBUS path. It asks for the EBUS and asserts DIAG_READ_FUNC_12x with a DIAG[4:6] register select. It waits for the EDP drive to settle, captures the 36-bit EBUS word and returns it to a requester over a valid/ready channel. It sits between DTE diagnostic logic and the EBUS, and is the consumer side of the EDP diagnostic-read driver.

Parameters:
SETTLE_CYCLES, 2, cycles DIAG function/select are held before sampling; legal range 1..15.
GRANT_TIMEOUT, 255, cycles spent waiting for ebus_grant before a timeout response; legal range 1..65535.

Ports:
clk  input  1  EBOX-domain clock; all state updates on posedge.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  1  read request present.
req_ready  output  1  block can accept a request (high only in IDLE).
req_sel  input  3  DIAG[4:6] code: 0 AR, 1 BR, 2 MQ, 3 FM, 4 BRX, 5 ARX, 6 ADX, 7 AD.
req_sweep  input  1  read registers req_sel..7 in sequence.
abort  input  1  synchronous cancel.
ebus_req  output  1  EBUS ownership request.
ebus_grant  input  1  EBUS granted to this block.
diag_read_func_12x  output  1  diagnostic read strobe to CTL/EDP.
diag_sel  output  3  DIAG[4:6] select.
ebus_data  input  36  EBUS data bits [0:35].
ebus_parity  input  1  EBUS parity bit (used only with the optional feature).
rsp_valid  output  1  response present.
rsp_ready  input  1  response consumed.
rsp_sel  output  3  register code the response came from.
rsp_data  output  36  captured word.
rsp_last  output  1  final response of the request.
rsp_tmo  output  1  grant timeout occurred; rsp_data = 0.
rsp_perr  output  1  parity error on the captured word.

Behaviour:
- Reset: state IDLE; every output is 0 except req_ready = 1; all counters cleared.
- FSM states: IDLE, ARB, DRIVE, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch req_sel into cur_sel and latch req_sweep; go to ARB.
- ARB:
  - ebus_req = 1; timeout counter increments each cycle.
  - ebus_grant = 1 → go to DRIVE with the settle counter loaded to SETTLE_CYCLES.
  - Counter reaches GRANT_TIMEOUT with no grant → go to RESP with rsp_tmo = 1, rsp_data = 0, rsp_last = 1. A timeout ends the sweep.
- DRIVE:
  - ebus_req = 1, diag_read_func_12x = 1, diag_sel = cur_sel; settle counter decrements each cycle.
  - Duration is exactly SETTLE_CYCLES cycles.
  - At the edge ending the last DRIVE cycle, register ebus_data into rsp_data and go to RESP.
  - If ebus_grant drops during DRIVE: deassert the diag outputs next cycle, return to ARB, reload the settle counter, and clear the timeout counter.
- RESP:
  - rsp_valid = 1; ebus_req, diag_read_func_12x and diag_sel = 0.
  - rsp_* fields stay stable until the handshake.
  - rsp_last = 1 when sweep is off, or cur_sel = 7, or a timeout occurred.
  - On rsp_valid & rsp_ready: if rsp_last = 1 go to IDLE; otherwise cur_sel + 1 and go to ARB (each register is re-arbitrated).
- Latency: accept at edge 0 with immediate grant and rsp_ready = 1 → rsp_valid high 2 + SETTLE_CYCLES cycles later (4 cycles at the default).
- Sweep from sel 0 gives 8 responses; the sel counter never wraps past 7.
- abort = 1 in any state → IDLE at the next edge; all outputs drop; any pending response is discarded. abort is ignored in IDLE, and it has priority over a simultaneous req_valid.
- rst_n asserted mid-operation → immediate return to the reset values above; no response is produced.

Optional Feature:
EDP_DIAG_PARITY_EN.
- Defined: at the sample edge, rsp_perr = (^ebus_data) ^ ebus_parity ^ 1 (odd parity over 37 bits); the read still completes normally.
- Undefined: rsp_perr is tied to 0 and ebus_parity is unused.

Decomposition:
- Shared package edp_diag_pkg holds:
  - diag select enum (DIAG_AR .. DIAG_AD, 3 bits);
  - FSM state typedef;
  - 36-bit word typedef.
- One natural sub-module, edp_diag_settle_ctr: a loadable down-counter with a zero flag. It is reused for both the settle count and the grant timeout.

Test Plan:
- Grant tied high, req_sel = 0, ebus_data = 36'o123456_701234, rsp_ready = 1 → diag_sel = 0 with strobe for exactly 2 cycles; rsp_valid at cycle 4; rsp_data = 36'o123456_701234; rsp_last = 1.
- req_sel = 5 with sweep, ebus_data = sel·36'o1 → three responses with sel 5, 6, 7, data 5, 6, 7; rsp_last only on sel 7; ebus_req drops between responses.
- Grant never asserted, GRANT_TIMEOUT = 10 → rsp_tmo = 1 and rsp_data = 0 at cycle 11; the sweep terminates.
- Grant dropped in the first DRIVE cycle and restored 3 cycles later → diag strobe restarts, with SETTLE_CYCLES full cycles before sampling.
- rsp_ready held low for 5 cycles → rsp_* stable and diag outputs low throughout; abort during RESP → IDLE with no response delivered.
- With EDP_DIAG_PARITY_EN: ebus_data = 36'o1, ebus_parity = 1 → rsp_perr = 1; same data with parity 0 → rsp_perr = 0.

Source files
------------

// File: rtl/edp_diag_pkg.sv
//============================================================================
// Module   : edp_diag_pkg
// Brief    : Shared types for the EDP diagnostic EBUS reader: DIAG[4:6]
//            register select codes, reader FSM states and the EBUS word.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package edp_diag_pkg;

    // DIAG[4:6] register select codes driven towards CTL/EDP
    typedef enum logic [2:0] {
        DIAG_AR  = 3'd0,
        DIAG_BR  = 3'd1,
        DIAG_MQ  = 3'd2,
        DIAG_FM  = 3'd3,
        DIAG_BRX = 3'd4,
        DIAG_ARX = 3'd5,
        DIAG_ADX = 3'd6,
        DIAG_AD  = 3'd7
    } diag_sel_e;

    // Reader FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_DRIVE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // EBUS data word, bits [0:35] carried as [35:0]
    localparam int c_WORD_W = 36;
    typedef logic [c_WORD_W-1:0] word_t;

endpackage

`default_nettype wire

// File: rtl/edp_diag_settle_ctr.sv
//============================================================================
// Module   : edp_diag_settle_ctr
// Brief    : Loadable down-counter with a zero flag. Counts down to zero and
//            holds there; a load always wins over a decrement.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module edp_diag_settle_ctr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load, or decrement towards zero and saturate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/edp_diag_reader.sv
//============================================================================
// Module   : edp_diag_reader
// Brief    : Front-end reader for the EDP diagnostic EBUS path. Arbitrates
//            for the EBUS, drives DIAG_READ_FUNC_12x with a DIAG[4:6] select,
//            waits SETTLE_CYCLES, captures the 36-bit word and returns it on
//            a valid/ready channel. Optional sweep reads req_sel..7.
//            Optional macro EDP_DIAG_PARITY_EN enables odd-parity checking
//            of the captured word (rsp_perr); otherwise rsp_perr is 0.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module edp_diag_reader
    import edp_diag_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int GRANT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [2:0]  i_req_sel,
    input  logic        i_req_sweep,
    input  logic        i_abort,
    output logic        o_ebus_req,
    input  logic        i_ebus_grant,
    output logic        o_diag_read_func_12x,
    output logic [2:0]  o_diag_sel,
    input  logic [35:0] i_ebus_data,
    input  logic        i_ebus_parity,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [2:0]  o_rsp_sel,
    output logic [35:0] o_rsp_data,
    output logic        o_rsp_last,
    output logic        o_rsp_tmo,
    output logic        o_rsp_perr
);

    // Counters are loaded with N-1 so that the zero flag marks the N-th cycle
    localparam logic [3:0]  c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [15:0] c_TMO_LOAD    = 16'(GRANT_TIMEOUT - 1);

    state_e    r_state;
    state_e    w_next;
    diag_sel_e r_cur_sel;
    logic      r_sweep;
    word_t     r_rsp_data;
    logic      r_tmo;
    logic      r_perr;

    logic w_settle_load;
    logic w_settle_zero;
    logic w_tmo_load;
    logic w_tmo_zero;
    logic w_accept;
    logic w_advance;
    logic w_capture;
    logic w_timeout;
    logic w_last;
    logic w_perr;

`ifdef EDP_DIAG_PARITY_EN
    // Odd parity across the 36 data bits plus the parity bit
    assign w_perr = (^i_ebus_data) ^ i_ebus_parity ^ 1'b1;
`else
    logic w_unused_parity;
    assign w_unused_parity = i_ebus_parity;
    assign w_perr          = 1'b0;
`endif

    // A timeout, a non-sweep read or register AD ends the request
    assign w_last = r_tmo | ~r_sweep | (r_cur_sel == DIAG_AD);

    edp_diag_settle_ctr #(
        .WIDTH (4)
    ) u_settle_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_settle_load),
        .i_load_val (c_SETTLE_LOAD),
        .i_dec      (r_state == ST_DRIVE),
        .o_zero     (w_settle_zero)
    );

    edp_diag_settle_ctr #(
        .WIDTH (16)
    ) u_tmo_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmo_load),
        .i_load_val (c_TMO_LOAD),
        .i_dec      (r_state == ST_ARB),
        .o_zero     (w_tmo_zero)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-dependent outputs
    always_comb begin
        w_next               = r_state;
        w_settle_load        = 1'b0;
        w_tmo_load           = 1'b0;
        w_accept             = 1'b0;
        w_advance            = 1'b0;
        w_capture            = 1'b0;
        w_timeout            = 1'b0;
        o_req_ready          = 1'b0;
        o_ebus_req           = 1'b0;
        o_diag_read_func_12x = 1'b0;
        o_diag_sel           = 3'd0;
        o_rsp_valid          = 1'b0;
        o_rsp_sel            = 3'd0;
        o_rsp_data           = '0;
        o_rsp_last           = 1'b0;
        o_rsp_tmo            = 1'b0;
        o_rsp_perr           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                // abort beats a simultaneous request
                if (i_req_valid && !i_abort) begin
                    w_next     = ST_ARB;
                    w_tmo_load = 1'b1;
                    w_accept   = 1'b1;
                end
            end
            ST_ARB: begin
                o_ebus_req = 1'b1;
                if (i_abort) begin
                    w_next = ST_IDLE;
                end else if (i_ebus_grant) begin
                    w_next        = ST_DRIVE;
                    w_settle_load = 1'b1;
                end else if (w_tmo_zero) begin
                    w_next    = ST_RESP;
                    w_timeout = 1'b1;
                end
            end
            ST_DRIVE: begin
                o_ebus_req           = 1'b1;
                o_diag_read_func_12x = 1'b1;
                o_diag_sel           = r_cur_sel;
                if (i_abort) begin
                    w_next = ST_IDLE;
                end else if (!i_ebus_grant) begin
                    // Lost the bus: re-arbitrate with fresh counters
                    w_next        = ST_ARB;
                    w_tmo_load    = 1'b1;
                    w_settle_load = 1'b1;
                end else if (w_settle_zero) begin
                    w_next    = ST_RESP;
                    w_capture = 1'b1;
                end
            end
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_sel   = r_cur_sel;
                o_rsp_data  = r_rsp_data;
                o_rsp_last  = w_last;
                o_rsp_tmo   = r_tmo;
                o_rsp_perr  = r_perr;
                if (i_abort) begin
                    w_next = ST_IDLE;
                end else if (i_rsp_ready) begin
                    if (w_last) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_next     = ST_ARB;
                        w_tmo_load = 1'b1;
                        w_advance  = 1'b1;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request context and captured response fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_sel  <= DIAG_AR;
            r_sweep    <= 1'b0;
            r_rsp_data <= '0;
            r_tmo      <= 1'b0;
            r_perr     <= 1'b0;
        end else if (w_accept) begin
            r_cur_sel  <= diag_sel_e'(i_req_sel);
            r_sweep    <= i_req_sweep;
            r_rsp_data <= '0;
            r_tmo      <= 1'b0;
            r_perr     <= 1'b0;
        end else if (w_advance) begin
            r_cur_sel <= diag_sel_e'(r_cur_sel + 3'd1);
            r_tmo     <= 1'b0;
        end else if (w_capture) begin
            r_rsp_data <= i_ebus_data;
            r_perr     <= w_perr;
            r_tmo      <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_perr     <= 1'b0;
            r_tmo      <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_edp_diag_reader.sv
//============================================================================
// Module   : tb_edp_diag_reader
// Brief    : Directed self-checking bench for edp_diag_reader
//            (SETTLE_CYCLES = 2, GRANT_TIMEOUT = 10).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_edp_diag_reader;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_sel;
    logic        req_sweep;
    logic        abort;
    logic        ebus_req;
    logic        ebus_grant;
    logic        diag_strobe;
    logic [2:0]  diag_sel;
    logic [35:0] ebus_data;
    logic        ebus_parity;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_sel;
    logic [35:0] rsp_data;
    logic        rsp_last;
    logic        rsp_tmo;
    logic        rsp_perr;

    int n_checks = 0;
    int n_fail   = 0;

    edp_diag_reader #(
        .SETTLE_CYCLES (2),
        .GRANT_TIMEOUT (10)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_req_valid          (req_valid),
        .o_req_ready          (req_ready),
        .i_req_sel            (req_sel),
        .i_req_sweep          (req_sweep),
        .i_abort              (abort),
        .o_ebus_req           (ebus_req),
        .i_ebus_grant         (ebus_grant),
        .o_diag_read_func_12x (diag_strobe),
        .o_diag_sel           (diag_sel),
        .i_ebus_data          (ebus_data),
        .i_ebus_parity        (ebus_parity),
        .o_rsp_valid          (rsp_valid),
        .i_rsp_ready          (rsp_ready),
        .o_rsp_sel            (rsp_sel),
        .o_rsp_data           (rsp_data),
        .o_rsp_last           (rsp_last),
        .o_rsp_tmo            (rsp_tmo),
        .o_rsp_perr           (rsp_perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One register read, entered from IDLE (with req_valid) or from RESP
    task automatic run_reg(input logic [2:0] sel, input logic [35:0] data, input logic last);
        ebus_data = data;
        tick();
        chk("arb_req",    36'(ebus_req),    36'd1);
        chk("arb_strobe", 36'(diag_strobe), 36'd0);
        tick();
        chk("drv1_strobe", 36'(diag_strobe), 36'd1);
        chk("drv1_sel",    36'(diag_sel),    36'(sel));
        tick();
        chk("drv2_strobe", 36'(diag_strobe), 36'd1);
        chk("drv2_valid",  36'(rsp_valid),   36'd0);
        tick();
        chk("rsp_valid",  36'(rsp_valid),   36'd1);
        chk("rsp_sel",    36'(rsp_sel),     36'(sel));
        chk("rsp_data",   rsp_data,         data);
        chk("rsp_last",   36'(rsp_last),    36'(last));
        chk("rsp_tmo",    36'(rsp_tmo),     36'd0);
        chk("rsp_ebreq",  36'(ebus_req),    36'd0);
        chk("rsp_strobe", 36'(diag_strobe), 36'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_sel     = 3'd0;
        req_sweep   = 1'b0;
        abort       = 1'b0;
        ebus_grant  = 1'b0;
        ebus_data   = 36'd0;
        ebus_parity = 1'b0;
        rsp_ready   = 1'b0;
        #12;
        chk("rst_req_ready", 36'(req_ready),   36'd1);
        chk("rst_ebus_req",  36'(ebus_req),    36'd0);
        chk("rst_strobe",    36'(diag_strobe), 36'd0);
        chk("rst_diag_sel",  36'(diag_sel),    36'd0);
        chk("rst_rsp_valid", 36'(rsp_valid),   36'd0);
        chk("rst_rsp_data",  rsp_data,         36'd0);
        chk("rst_rsp_last",  36'(rsp_last),    36'd0);
        chk("rst_rsp_tmo",   36'(rsp_tmo),     36'd0);
        chk("rst_rsp_perr",  36'(rsp_perr),    36'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single read of AR, grant tied high
        ebus_grant = 1'b1;
        rsp_ready  = 1'b1;
        req_sel    = 3'd0;
        req_valid  = 1'b1;
        chk("t1_req_ready", 36'(req_ready), 36'd1);
        run_reg(3'd0, 36'o123456701234, 1'b1);
        req_valid = 1'b0;
        tick();
        chk("t1_idle_ready", 36'(req_ready), 36'd1);
        chk("t1_idle_valid", 36'(rsp_valid), 36'd0);

        // Sweep from ARX: 5, 6, 7
        req_sel   = 3'd5;
        req_sweep = 1'b1;
        req_valid = 1'b1;
        run_reg(3'd5, 36'd5, 1'b0);
        req_valid = 1'b0;
        req_sweep = 1'b0;
        run_reg(3'd6, 36'd6, 1'b0);
        run_reg(3'd7, 36'd7, 1'b1);
        tick();
        chk("t2_idle_ready", 36'(req_ready), 36'd1);
        chk("t2_idle_ebreq", 36'(ebus_req),  36'd0);

        // Grant never arrives: timeout after 10 ARB cycles, sweep ends
        ebus_grant = 1'b0;
        ebus_data  = 36'o777;
        req_sel    = 3'd3;
        req_sweep  = 1'b1;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        req_sweep = 1'b0;
        repeat (9) tick();
        chk("t3_arb10_req",   36'(ebus_req),  36'd1);
        chk("t3_arb10_valid", 36'(rsp_valid), 36'd0);
        tick();
        chk("t3_tmo_valid", 36'(rsp_valid), 36'd1);
        chk("t3_tmo_flag",  36'(rsp_tmo),   36'd1);
        chk("t3_tmo_data",  rsp_data,       36'd0);
        chk("t3_tmo_last",  36'(rsp_last),  36'd1);
        chk("t3_tmo_sel",   36'(rsp_sel),   36'd3);
        tick();
        chk("t3_idle_ready", 36'(req_ready), 36'd1);
        chk("t3_idle_ebreq", 36'(ebus_req),  36'd0);

        // Late grant, dropped in first DRIVE cycle, restored after 3 cycles
        req_sel   = 3'd2;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (8) tick();
        chk("t4_arb9_req",   36'(ebus_req),  36'd1);
        chk("t4_arb9_valid", 36'(rsp_valid), 36'd0);
        ebus_grant = 1'b1;
        tick();
        chk("t4_drv_strobe", 36'(diag_strobe), 36'd1);
        chk("t4_drv_sel",    36'(diag_sel),    36'd2);
        ebus_grant = 1'b0;
        tick();
        chk("t4_drop_strobe", 36'(diag_strobe), 36'd0);
        chk("t4_drop_req",    36'(ebus_req),    36'd1);
        tick();
        tick();
        chk("t4_rearb_valid", 36'(rsp_valid), 36'd0);
        chk("t4_rearb_req",   36'(ebus_req),  36'd1);
        ebus_grant = 1'b1;
        ebus_data  = 36'o4242;
        tick();
        chk("t4_re_drv1", 36'(diag_strobe), 36'd1);
        tick();
        chk("t4_re_drv2",  36'(diag_strobe), 36'd1);
        chk("t4_re_valid", 36'(rsp_valid),   36'd0);
        tick();
        chk("t4_rsp_valid", 36'(rsp_valid), 36'd1);
        chk("t4_rsp_data",  rsp_data,       36'o4242);
        chk("t4_rsp_tmo",   36'(rsp_tmo),   36'd0);
        chk("t4_rsp_last",  36'(rsp_last),  36'd1);
        tick();

        // Back-pressure for 5 cycles, then abort discards the response
        rsp_ready = 1'b0;
        req_sel   = 3'd4;
        req_valid = 1'b1;
        run_reg(3'd4, 36'o55, 1'b1);
        req_valid = 1'b0;
        ebus_data = 36'o66;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_valid",  36'(rsp_valid),   36'd1);
            chk("t5_hold_data",   rsp_data,         36'o55);
            chk("t5_hold_sel",    36'(rsp_sel),     36'd4);
            chk("t5_hold_strobe", 36'(diag_strobe), 36'd0);
            chk("t5_hold_ebreq",  36'(ebus_req),    36'd0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_valid", 36'(rsp_valid), 36'd0);
        chk("t5_abort_data",  rsp_data,       36'd0);
        chk("t5_abort_ready", 36'(req_ready), 36'd1);
        rsp_ready = 1'b1;
        tick();
        chk("t5_after_valid", 36'(rsp_valid), 36'd0);

        // abort beats a simultaneous request in IDLE
        abort     = 1'b1;
        req_valid = 1'b1;
        tick();
        chk("t6_prio_ebreq", 36'(ebus_req),  36'd0);
        chk("t6_prio_ready", 36'(req_ready), 36'd1);
        abort     = 1'b0;
        req_valid = 1'b0;

        // abort in DRIVE drops every output next edge
        req_sel   = 3'd1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("t7_drv_strobe", 36'(diag_strobe), 36'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t7_abort_strobe", 36'(diag_strobe), 36'd0);
        chk("t7_abort_ebreq",  36'(ebus_req),    36'd0);
        chk("t7_abort_ready",  36'(req_ready),   36'd1);
        tick();
        chk("t7_after_valid", 36'(rsp_valid), 36'd0);

        // Reset asserted mid-DRIVE
        req_sel   = 3'd6;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t8_rst_strobe", 36'(diag_strobe), 36'd0);
        chk("t8_rst_ebreq",  36'(ebus_req),    36'd0);
        chk("t8_rst_ready",  36'(req_ready),   36'd1);
        chk("t8_rst_valid",  36'(rsp_valid),   36'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t8_post_valid", 36'(rsp_valid), 36'd0);
        chk("t8_post_ready", 36'(req_ready), 36'd1);

        // Parity: data 1 with parity bit 1, then 0
        req_sel     = 3'd0;
        ebus_parity = 1'b1;
        req_valid   = 1'b1;
        run_reg(3'd0, 36'o1, 1'b1);
        req_valid = 1'b0;
`ifdef EDP_DIAG_PARITY_EN
        chk("t9_perr_p1", 36'(rsp_perr), 36'd1);
`else
        chk("t9_perr_p1", 36'(rsp_perr), 36'd0);
`endif
        tick();
        ebus_parity = 1'b0;
        req_valid   = 1'b1;
        run_reg(3'd0, 36'o1, 1'b1);
        req_valid = 1'b0;
        chk("t9_perr_p0", 36'(rsp_perr), 36'd0);
        tick();
        chk("t9_idle_ready", 36'(req_ready), 36'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
